// File: rtl/trivium_pkg.sv
// Shared constants, load layout and FSM encoding for the Trivium receive path.
package trivium_pkg;

  localparam int KEY_W       = 80;
  localparam int IV_W        = 80;
  localparam int STATE_W     = 288;
  localparam int INIT_ROUNDS = 1152;

  // Bit offsets of the loaded fields; s(n) lives at index n-1.
  localparam int KEY_LSB  = 0;
  localparam int IV_LSB   = 93;
  localparam int ONES_LSB = 285;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_STREAM
  } state_e;

  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] s;
    s = '0;
    s[KEY_LSB +: KEY_W] = key;
    s[IV_LSB +: IV_W]   = iv;
    s[ONES_LSB +: 3]    = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: 288-bit state in, advanced state and keystream bit out.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s_i,
  output logic [STATE_W-1:0] s_o,
  output logic               z_o
);

  logic t1, t2, t3;
  logic t1f, t2f, t3f;

  assign t1  = s_i[65]  ^ s_i[92];
  assign t2  = s_i[161] ^ s_i[176];
  assign t3  = s_i[242] ^ s_i[287];
  assign z_o = t1 ^ t2 ^ t3;

  assign t1f = t1 ^ (s_i[90]  & s_i[91])  ^ s_i[170];
  assign t2f = t2 ^ (s_i[174] & s_i[175]) ^ s_i[263];
  assign t3f = t3 ^ (s_i[285] & s_i[286]) ^ s_i[68];

  // Three shift registers, each fed at its low end by the other register's feedback.
  assign s_o = {s_i[286:177], t2f, s_i[175:93], t1f, s_i[91:0], t3f};

endmodule

// File: rtl/trivium_decrypt.sv
// Trivium keystream receiver: key/IV load, warm-up, then XOR of accepted ciphertext beats.
// Optional feature macro: TRIVIUM_IV_EN (when undefined, the IV port is ignored and loads zero).
module trivium_decrypt
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  output logic             init_done_o,
  input  logic             ct_valid_i,
  input  logic [W-1:0]     ct_data_i,
  output logic             ct_ready_o,
  output logic             pt_valid_o,
  output logic [W-1:0]     pt_data_o,
  input  logic             pt_ready_i
);

  localparam int INIT_CYC = INIT_ROUNDS / W;
  localparam int CNT_W    = $clog2(INIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYC - 1);

  if (W < 1 || W > 64 || (W & (W - 1)) != 0) begin : g_bad_w
    $error("trivium_decrypt: W must be a power of two in 1..64");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic               pt_valid_q, pt_valid_d;
  logic [W-1:0]       pt_data_q, pt_data_d;

  logic [IV_W-1:0]    iv_load;
  logic               ct_ready;
  logic               accept;

`ifdef TRIVIUM_IV_EN
  assign iv_load = iv_i;
`else
  logic unused_iv;
  assign iv_load   = '0;
  assign unused_iv = ^iv_i;
`endif

  // W rounds unrolled; z[k] is the keystream bit of round k within the beat.
  logic [W:0][STATE_W-1:0] chain;
  logic [W-1:0]            z;

  assign chain[0] = s_q;

  for (genvar k = 0; k < W; k++) begin : g_round
    trivium_round u_round (
      .s_i (chain[k]),
      .s_o (chain[k+1]),
      .z_o (z[k])
    );
  end

  // A start in the same cycle never takes a beat; it would be lost to the reload.
  assign ct_ready = (state_q == ST_STREAM) && (!pt_valid_q || pt_ready_i) && !start_i;
  assign accept   = ct_valid_i && ct_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    if (start_i) begin
      state_d    = ST_INIT;
      cnt_d      = '0;
      s_d        = load_state(key_i, iv_load);
      pt_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          s_d = chain[W];
          if (cnt_q == CNT_LAST) begin
            state_d = ST_STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            s_d        = chain[W];
            pt_valid_d = 1'b1;
            pt_data_d  = ct_data_i ^ z;
          end else if (pt_ready_i) begin
            pt_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
    end
  end

  assign init_done_o = (state_q == ST_STREAM);
  assign ct_ready_o  = ct_ready;
  assign pt_valid_o  = pt_valid_q;
  assign pt_data_o   = pt_data_q;

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt (W=8) against a bit-level Trivium reference model.
module tb_trivium_decrypt;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [79:0]  key, iv;
  logic         init_done, ct_valid, ct_ready, pt_valid, pt_ready;
  logic [W-1:0] ct_data, pt_data;

  always #5 clk = ~clk;

  trivium_decrypt #(.W(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .key_i       (key),
    .iv_i        (iv),
    .init_done_o (init_done),
    .ct_valid_i  (ct_valid),
    .ct_data_i   (ct_data),
    .ct_ready_o  (ct_ready),
    .pt_valid_o  (pt_valid),
    .pt_data_o   (pt_data),
    .pt_ready_i  (pt_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] ct_arr[$];
  logic [W-1:0] exp_arr[$];

  // Reference state, indexed exactly as s1..s288.
  bit [1:288] ms;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_round(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int n = 288; n >= 179; n--) ms[n] = ms[n-1];
    ms[178] = t2;
    for (int n = 177; n >= 95; n--) ms[n] = ms[n-1];
    ms[94] = t1;
    for (int n = 93; n >= 2; n--) ms[n] = ms[n-1];
    ms[1] = t3;
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    logic [79:0] ivm;
    bit z;
`ifdef TRIVIUM_IV_EN
    ivm = v;
`else
    ivm = v & 80'h0;  // fixed-IV build: IV bits load as zero
`endif
    ms = '0;
    for (int i = 0; i < 80; i++) begin
      ms[i+1]  = k[i];
      ms[i+94] = ivm[i];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int r = 0; r < 1152; r++) model_round(z);
  endtask

  task automatic model_beat(output logic [W-1:0] b);
    bit z;
    b = '0;
    for (int k = 0; k < W; k++) begin
      model_round(z);
      b[k] = z;
    end
  endtask

  // mode 0: zero ciphertext, 1: encrypt random plaintext, 2: random ciphertext
  task automatic prep(input int n, input int mode);
    logic [W-1:0] ks, p, c;
    for (int i = 0; i < n; i++) begin
      model_beat(ks);
      case (mode)
        0: begin c = '0; p = ks; end
        1: begin p = W'($urandom); c = p ^ ks; end
        default: begin c = W'($urandom); p = c ^ ks; end
      endcase
      ct_arr.push_back(c);
      exp_arr.push_back(p);
    end
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    @(posedge clk); #1;
    start = 1'b1; key = k; iv = v; ct_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_done_cycle", 64'(n + 1), 64'd145);
  endtask

  task automatic send(input bit rnd);
    int cyc, bound;
    cyc   = 0;
    bound = 20 * ct_arr.size() + 100;
    while (ct_arr.size() > 0 && cyc < bound) begin
      @(posedge clk); #1;
      ct_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ct_data  = ct_arr[0];
      pt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ct_valid && ct_ready) begin
        sb.push_back(exp_arr.pop_front());
        void'(ct_arr.pop_front());
      end
      cyc++;
    end
    if (ct_arr.size() > 0) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=%0d beats left required=0", ct_arr.size());
      ct_arr.delete();
      exp_arr.delete();
    end
  endtask

  task automatic drain();
    int cyc;
    @(posedge clk); #1;
    ct_valid = 1'b0;
    pt_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
    check({tag, "_ct_ready"},  64'(ct_ready),  64'd0);
    check({tag, "_pt_valid"},  64'(pt_valid),  64'd0);
    check({tag, "_pt_data"},   64'(pt_data),   64'd0);
  endtask

  task automatic check_stays_idle(input string tag, input int ncyc);
    bit bad;
    bad = 1'b0;
    ct_valid = 1'b1;
    pt_ready = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      if (pt_valid || init_done || ct_ready) bad = 1'b1;
    end
    ct_valid = 1'b0;
    check(tag, 64'(bad), 64'd0);
  endtask

  // Monitor: every delivered plaintext beat must match the oldest expectation.
  always @(negedge clk) begin
    if (pt_valid === 1'b1 && pt_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pt_unexpected actual=%0h required=no beat", pt_data);
      end else begin
        check("pt_data", 64'(pt_data), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] ka, kb, kc, kd;
    reset = 1'b1; start = 1'b0; key = '0; iv = '0;
    ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("rst");

    // All-zero key/IV keystream, back-to-back.
    model_load('0, '0);
    prep(64, 0);
    do_start('0, '0);
    wait_init();
    send(1'b0);
    drain();

    // Round trip of model-encrypted plaintext.
    ka = {16'($urandom), $urandom, $urandom};
    iv = {16'($urandom), $urandom, $urandom};
    model_load(ka, iv);
    prep(256, 1);
    do_start(ka, iv);
    wait_init();
    send(1'b0);
    drain();

    // Random valid/ready on both sides.
    kb = {16'($urandom), $urandom, $urandom};
    model_load(kb, '0);
    prep(1000, 2);
    do_start(kb, '0);
    wait_init();
    send(1'b1);
    drain();

    // Restart mid-stream with a beat held in the output register.
    kc = {16'($urandom), $urandom, $urandom};
    model_load(ka, '0);
    prep(100, 0);
    do_start(ka, '0);
    wait_init();
    send(1'b0);
    @(posedge clk); #1;
    ct_valid = 1'b0; pt_ready = 1'b0;
    @(negedge clk);
    check("pt_pending", 64'(pt_valid), 64'd1);
    @(posedge clk); #1;
    start = 1'b1; key = kc; ct_valid = 1'b1; ct_data = 8'hA5;
    @(negedge clk);
    check("ct_ready_on_start", 64'(ct_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    start = 1'b0; ct_valid = 1'b0;
    check("pt_dropped", 64'(pt_valid), 64'd0);
    wait_init();
    model_load(kc, '0);
    prep(8, 0);
    send(1'b0);
    drain();

    // Reset during warm-up, coincident with start.
    do_start(kb, '0);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_reset_outputs("rst_init");
    check_stays_idle("idle_after_rst_init", 200);

    // Reset while streaming with a beat pending.
    kd = {16'($urandom), $urandom, $urandom};
    model_load(kd, '0);
    prep(10, 0);
    do_start(kd, '0);
    wait_init();
    send(1'b0);
    @(posedge clk); #1;
    ct_valid = 1'b0; pt_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("rst_stream");
    check_stays_idle("idle_after_rst_stream", 30);

    // IV all-ones: matches the zero-IV keystream when the IV feature is off.
    model_load(kd, '1);
    prep(32, 0);
    do_start(kd, '1);
    wait_init();
    send(1'b0);
    drain();

    check("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
